// File: rtl/squash_unit_l2.sv
`default_nettype none
// ============================================================================
// Module      : squash_unit_l2
// Description : Multi-source squash arbiter. Picks the oldest valid squash
//               request (age measured from the commit pointer, wrap-safe),
//               issues it as a one-cycle registered grant, filters younger or
//               duplicate squashes while an older one is outstanding, and
//               keeps a saturating count of grants.
// Revision    : 1.0 - initial release
// ============================================================================
module squash_unit_l2 #(
    parameter int p_num_arb      = 4,
    parameter int p_seq_num_bits = 5,
    parameter int p_addr_bits    = 32,
    parameter int p_cnt_bits     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_num_arb-1:0]                arb_val,
    input  logic [p_num_arb*p_seq_num_bits-1:0] arb_seq_num,
    input  logic [p_num_arb*p_addr_bits-1:0]    arb_target,
    input  logic                                commit_val,
    input  logic [p_seq_num_bits-1:0]           commit_seq_num,
    output logic                                gnt_val,
    output logic [p_seq_num_bits-1:0]           gnt_seq_num,
    output logic [p_addr_bits-1:0]              gnt_target,
    output logic [p_cnt_bits-1:0]               squash_count
);

    localparam int                    c_s       = p_seq_num_bits;
    localparam int                    c_a       = p_addr_bits;
    localparam logic [p_cnt_bits-1:0] c_cnt_max = {p_cnt_bits{1'b1}};

    // Architectural state
    logic [c_s-1:0]        r_base;
    logic                  r_filt_val;
    logic [c_s-1:0]        r_filt_seq;
    logic                  r_gnt_val;
    logic [c_s-1:0]        r_gnt_seq;
    logic [c_a-1:0]        r_gnt_tgt;
    logic [p_cnt_bits-1:0] r_count;

    // Per-source age and eligibility
    logic [c_s-1:0]        w_age  [p_num_arb];
    logic [p_num_arb-1:0]  w_elig;
    logic [c_s-1:0]        w_filt_age;

    // Winner selection results
    logic                  w_found;
    logic [c_s-1:0]        w_best_age;
    logic [c_s-1:0]        w_best_seq;
    logic [c_a-1:0]        w_best_tgt;

    // Age is distance from the oldest uncommitted instruction; modular
    // subtraction keeps ordering correct across sequence-number wrap.
    assign w_filt_age = r_filt_seq - r_base;

    generate
        for (genvar gi = 0; gi < p_num_arb; gi++) begin : g_src
            assign w_age[gi]  = arb_seq_num[gi*c_s +: c_s] - r_base;
            // A request no older than the outstanding squash is already
            // covered by it (equal seq is a duplicate) and is dropped.
            assign w_elig[gi] = arb_val[gi] &&
                                !(r_filt_val && (w_age[gi] >= w_filt_age));
        end
    endgenerate

    // Oldest eligible source wins; strict compare keeps lowest index on ties
    always_comb begin
        w_found    = 1'b0;
        w_best_age = '0;
        w_best_seq = '0;
        w_best_tgt = '0;
        for (int i = 0; i < p_num_arb; i++) begin
            if (w_elig[i] && (!w_found || (w_age[i] < w_best_age))) begin
                w_found    = 1'b1;
                w_best_age = w_age[i];
                w_best_seq = arb_seq_num[i*c_s +: c_s];
                w_best_tgt = arb_target[i*c_a +: c_a];
            end
        end
    end

    // Grant register: one-cycle pulse, payload holds when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_val <= 1'b0;
            r_gnt_seq <= '0;
            r_gnt_tgt <= '0;
        end else begin
            r_gnt_val <= w_found;
            if (w_found) begin
                r_gnt_seq <= w_best_seq;
                r_gnt_tgt <= w_best_tgt;
            end
        end
    end

    // Filter tracks the outstanding squash; a new grant beats a retiring commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_val <= 1'b0;
            r_filt_seq <= '0;
        end else if (w_found) begin
            r_filt_val <= 1'b1;
            r_filt_seq <= w_best_seq;
        end else if (commit_val && r_filt_val && (commit_seq_num == r_filt_seq)) begin
            r_filt_val <= 1'b0;
        end
    end

    // Commit pointer advances past each committing instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base <= '0;
        end else if (commit_val) begin
            r_base <= commit_seq_num + 1'b1;
        end
    end

    // Saturating grant counter for performance tracing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_found && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign gnt_val      = r_gnt_val;
    assign gnt_seq_num  = r_gnt_seq;
    assign gnt_target   = r_gnt_tgt;
    assign squash_count = r_count;

endmodule
`default_nettype wire
